// File: rtl/ltc6912_chain_ctrl_if.sv
// Request/status and SPI signal bundle for the LTC6912 daisy-chain gain controller.
interface ltc6912_chain_ctrl_if #(
    parameter int N_DEV = 1
);
    logic [8*N_DEV-1:0] gain_data;
    logic               gain_valid;
    logic               gain_ready;
    logic               busy;
    logic               done;
    logic               error;
    logic               cs;
    logic               sck;
    logic               mosi;
    logic               miso;

    modport master (
        output gain_data, gain_valid, miso,
        input  gain_ready, busy, done, error, cs, sck, mosi
    );

    modport slave (
        input  gain_data, gain_valid, miso,
        output gain_ready, busy, done, error, cs, sck, mosi
    );
endinterface

// File: rtl/ltc6912_chain_ctrl.sv
// SPI mode-0 gain programmer for a chain of N_DEV LTC6912 PGAs; sends INIT_GAIN after reset.
// Define LTC6912_CHAIN_READBACK_EN to send each frame twice and check the echoed word on miso.
module ltc6912_chain_ctrl #(
    parameter int         N_DEV     = 1,
    parameter int         CLK_DIV   = 4,
    parameter logic [7:0] INIT_GAIN = 8'b0111_0111
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ltc6912_chain_ctrl_if.slave  bus
);
    localparam int W  = 8 * N_DEV;
    localparam int CW = $clog2(W + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {INIT, IDLE, SHIFT, GAP, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    tx_word;
    logic [W-1:0]    shift_reg;
    logic [CW-1:0]   bit_cnt;
    logic [DW-1:0]   div_cnt;
    logic            phase;
    logic            busy_q;
    logic            div_end;
    logic            frame_over;

`ifdef LTC6912_CHAIN_READBACK_EN
    logic            second;
    logic [W-1:0]    rx_reg;
    logic            error_q;
`else
    logic            unused_miso;
    assign unused_miso = bus.miso;
`endif

    assign div_end    = (div_cnt == DW'(CLK_DIV - 1));
    assign frame_over = (bit_cnt == CW'(W));

    // Next state and all SPI/handshake outputs are decoded from the current state.
    always_comb begin
        state_next     = state;
        bus.gain_ready = 1'b0;
        bus.done       = 1'b0;
        bus.cs         = 1'b1;
        bus.sck        = 1'b0;
        bus.mosi       = 1'b0;
        case (state)
            INIT: state_next = SHIFT;
            IDLE: begin
                bus.gain_ready = 1'b1;
                if (bus.gain_valid) state_next = SHIFT;
            end
            SHIFT: begin
                bus.cs   = 1'b0;
                bus.sck  = phase;
                bus.mosi = shift_reg[W-1];
                if (frame_over && div_end) state_next = GAP;
            end
            GAP: begin
                if (div_end) begin
`ifdef LTC6912_CHAIN_READBACK_EN
                    state_next = second ? DONE : SHIFT;
`else
                    state_next = DONE;
`endif
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = INIT;
        endcase
    end

    // phase=0 is the sck-low half with a bit on mosi; the bit advances when sck falls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= INIT;
            busy_q    <= 1'b0;
            tx_word   <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            phase     <= 1'b0;
`ifdef LTC6912_CHAIN_READBACK_EN
            second    <= 1'b0;
            rx_reg    <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            busy_q <= (state_next != IDLE);
            case (state)
                INIT: begin
                    tx_word   <= {N_DEV{INIT_GAIN}};
                    shift_reg <= {N_DEV{INIT_GAIN}};
                    bit_cnt   <= '0;
                    div_cnt   <= '0;
                    phase     <= 1'b0;
`ifdef LTC6912_CHAIN_READBACK_EN
                    second    <= 1'b0;
`endif
                end
                IDLE: begin
                    if (bus.gain_valid) begin
                        tx_word   <= bus.gain_data;
                        shift_reg <= bus.gain_data;
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                        phase     <= 1'b0;
`ifdef LTC6912_CHAIN_READBACK_EN
                        second    <= 1'b0;
                        error_q   <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    div_cnt <= div_end ? '0 : div_cnt + DW'(1);
                    if (div_end && !frame_over) begin
                        phase <= ~phase;
                        if (phase) begin
                            shift_reg <= {shift_reg[W-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + CW'(1);
                        end
`ifdef LTC6912_CHAIN_READBACK_EN
                        else begin
                            rx_reg <= {rx_reg[W-2:0], bus.miso};
                        end
`endif
                    end
                end
                GAP: begin
                    div_cnt <= div_end ? '0 : div_cnt + DW'(1);
                    if (div_end) begin
                        shift_reg <= tx_word;
                        bit_cnt   <= '0;
`ifdef LTC6912_CHAIN_READBACK_EN
                        second    <= 1'b1;
                        if (second) error_q <= (rx_reg != tx_word);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
`ifdef LTC6912_CHAIN_READBACK_EN
    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_ltc6912_chain_ctrl.sv
// Directed bench: chain A (N_DEV=2, CLK_DIV=2) and chain B (N_DEV=1, CLK_DIV=1) share clk/reset_n.
module tb_ltc6912_chain_ctrl;
`ifdef LTC6912_CHAIN_READBACK_EN
    localparam int FPS = 2;
    localparam logic RB = 1'b1;
`else
    localparam int FPS = 1;
    localparam logic RB = 1'b0;
`endif
    localparam int LEN_A = 2 * 2 * 16 + 2;
    localparam int LEN_B = 2 * 1 * 8 + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ltc6912_chain_ctrl_if #(.N_DEV(2)) bus_a ();
    ltc6912_chain_ctrl_if #(.N_DEV(1)) bus_b ();

    ltc6912_chain_ctrl #(.N_DEV(2), .CLK_DIV(2)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    ltc6912_chain_ctrl #(.N_DEV(1), .CLK_DIV(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    int n_checks = 0;
    int n_fail   = 0;

    // Two LTC6912s behave as one 16-bit shift chain clocked on sck rising edges.
    logic [15:0] chain = 16'h0000;
    logic        miso_stuck = 1'b0;
    always @(posedge bus_a.sck) chain <= {chain[14:0], bus_a.mosi};
    assign bus_a.miso = miso_stuck ? 1'b0 : chain[15];
    assign bus_b.miso = 1'b0;

    // Frame monitor for chain A, sampled on the falling clk edge.
    logic [31:0] a_cnt = 0, a_len = 0, a_rises = 0, a_cur_rises = 0;
    logic [31:0] a_gap = 0, a_gap_done = 0, a_frames = 0, a_busy_bad = 0;
    logic [15:0] a_bits = 0, a_cur_bits = 0;
    logic        a_sck_d = 1'b0;
    always @(negedge clk) begin
        a_sck_d <= bus_a.sck;
        if (!bus_a.cs) begin
            a_cnt <= a_cnt + 1;
            a_gap <= 0;
            if (!bus_a.busy) a_busy_bad <= a_busy_bad + 1;
            if (bus_a.sck && !a_sck_d) begin
                a_cur_bits  <= {a_cur_bits[14:0], bus_a.mosi};
                a_cur_rises <= a_cur_rises + 1;
            end
        end else begin
            if (a_cnt != 0) begin
                a_len       <= a_cnt;
                a_bits      <= a_cur_bits;
                a_rises     <= a_cur_rises;
                a_frames    <= a_frames + 1;
                a_cnt       <= 0;
                a_cur_rises <= 0;
            end
            if (bus_a.done) a_gap_done <= a_gap;
            else            a_gap <= a_gap + 1;
        end
    end

    // Frame monitor for chain B.
    logic [31:0] b_cnt = 0, b_len = 0, b_rises = 0, b_cur_rises = 0;
    logic [31:0] b_hi = 0, b_cur_hi = 0, b_done_cnt = 0;
    logic [7:0]  b_bits = 0, b_cur_bits = 0;
    logic        b_sck_d = 1'b0;
    always @(negedge clk) begin
        b_sck_d <= bus_b.sck;
        if (bus_b.done) b_done_cnt <= b_done_cnt + 1;
        if (!bus_b.cs) begin
            b_cnt <= b_cnt + 1;
            if (bus_b.sck) b_cur_hi <= b_cur_hi + 1;
            if (bus_b.sck && !b_sck_d) begin
                b_cur_bits  <= {b_cur_bits[6:0], bus_b.mosi};
                b_cur_rises <= b_cur_rises + 1;
            end
        end else if (b_cnt != 0) begin
            b_len       <= b_cnt;
            b_bits      <= b_cur_bits;
            b_rises     <= b_cur_rises;
            b_hi        <= b_cur_hi;
            b_cnt       <= 0;
            b_cur_rises <= 0;
            b_cur_hi    <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] data);
        @(negedge clk);
        checkOutput("ready_before_accept", 32'(bus_a.gain_ready), 32'd1);
        bus_a.gain_data  = data;
        bus_a.gain_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_a.gain_valid = 1'b0;
    endtask

    task automatic waitDoneA(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_a.done && n < 2000);
        checkOutput(tag, 32'(bus_a.done), 32'd1);
        #1;
    endtask

    initial begin
        logic [31:0] f0;
        logic [31:0] bd0;
        int n;
        bus_a.gain_valid = 1'b0;
        bus_a.gain_data  = '0;
        bus_b.gain_valid = 1'b0;
        bus_b.gain_data  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_cs",    32'(bus_a.cs), 32'd1);
        checkOutput("rst_sck",   32'(bus_a.sck), 32'd0);
        checkOutput("rst_mosi",  32'(bus_a.mosi), 32'd0);
        checkOutput("rst_ready", 32'(bus_a.gain_ready), 32'd0);
        checkOutput("rst_busy",  32'(bus_a.busy), 32'd0);
        checkOutput("rst_done",  32'(bus_a.done), 32'd0);
        checkOutput("rst_error", 32'(bus_a.error), 32'd0);

        // Init sequence after release
        f0 = a_frames;
        reset_n = 1'b1;
        waitDoneA("init_done_seen");
        checkOutput("init_len",    a_len, LEN_A);
        checkOutput("init_bits",   32'(a_bits), 32'h7777);
        checkOutput("init_rises",  a_rises, 32'd16);
        checkOutput("init_gap",    a_gap_done, 32'd2);
        checkOutput("init_frames", a_frames - f0, FPS);
        checkOutput("init_busy",   a_busy_bad, 32'd0);
        checkOutput("init_ready_in_done", 32'(bus_a.gain_ready), 32'd0);
        checkOutput("init_error",  32'(bus_a.error), 32'd0);
        @(negedge clk);
        checkOutput("init_ready_after", 32'(bus_a.gain_ready), 32'd1);
        checkOutput("init_busy_after",  32'(bus_a.busy), 32'd0);
        checkOutput("b_init_len",   b_len, LEN_B);
        checkOutput("b_init_bits",  32'(b_bits), 32'h77);
        checkOutput("b_init_rises", b_rises, 32'd8);
        checkOutput("b_init_hi",    b_hi, 32'd8);
        checkOutput("b_init_done",  b_done_cnt, 32'd1);

        // Normal programming of 0xA53C
        f0 = a_frames;
        applyStimulus(16'hA53C);
        @(negedge clk);
        checkOutput("a53c_ready_low", 32'(bus_a.gain_ready), 32'd0);
        checkOutput("a53c_busy",      32'(bus_a.busy), 32'd1);
        checkOutput("a53c_cs_low",    32'(bus_a.cs), 32'd0);
        checkOutput("a53c_first_bit", 32'(bus_a.mosi), 32'd1);
        waitDoneA("a53c_done_seen");
        checkOutput("a53c_bits",   32'(a_bits), 32'hA53C);
        checkOutput("a53c_rises",  a_rises, 32'd16);
        checkOutput("a53c_len",    a_len, LEN_A);
        checkOutput("a53c_frames", a_frames - f0, FPS);
        checkOutput("a53c_busy_all", a_busy_bad, 32'd0);

        // gain_valid held during busy with changing data
        @(negedge clk);
        bus_a.gain_data  = 16'h1234;
        bus_a.gain_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            bus_a.gain_data = 16'($urandom);
            n++;
        end while (!bus_a.done && n < 2000);
        bus_a.gain_valid = 1'b0;
        checkOutput("hold_done_seen", 32'(bus_a.done), 32'd1);
        #1;
        checkOutput("hold_bits", 32'(a_bits), 32'h1234);
        @(negedge clk);
        @(negedge clk);
        checkOutput("hold_no_requeue", 32'(bus_a.busy), 32'd0);

        // Chain B programming
        @(negedge clk);
        bd0 = b_done_cnt;
        bus_b.gain_data  = 8'hC3;
        bus_b.gain_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_b.gain_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_b.done && n < 500);
        checkOutput("b_c3_done_seen", 32'(bus_b.done), 32'd1);
        @(negedge clk);
        checkOutput("b_c3_bits",  32'(b_bits), 32'hC3);
        checkOutput("b_c3_len",   b_len, LEN_B);
        checkOutput("b_c3_hi",    b_hi, 32'd8);
        checkOutput("b_c3_pulses", b_done_cnt - bd0, 32'd1);

        // Reset in the middle of a frame
        applyStimulus(16'hFFFF);
        n = 0;
        while (a_cur_rises < 7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("mid_reached_bit7", a_cur_rises, 32'd7);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_cs",   32'(bus_a.cs), 32'd1);
        checkOutput("mid_sck",  32'(bus_a.sck), 32'd0);
        checkOutput("mid_done", 32'(bus_a.done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        waitDoneA("mid_init_done_seen");
        checkOutput("mid_init_bits", 32'(a_bits), 32'h7777);
        checkOutput("mid_init_len",  a_len, LEN_A);

        // Readback checking (error stays 0 without readback)
        miso_stuck = 1'b0;
        applyStimulus(16'h1234);
        waitDoneA("rb_good_done_seen");
        checkOutput("rb_good_error", 32'(bus_a.error), 32'd0);
        miso_stuck = 1'b1;
        applyStimulus(16'h5A5A);
        waitDoneA("rb_bad_done_seen");
        checkOutput("rb_bad_error", 32'(bus_a.error), 32'(RB));
        @(negedge clk);
        checkOutput("rb_bad_sticky", 32'(bus_a.error), 32'(RB));
        miso_stuck = 1'b0;
        applyStimulus(16'h0F0F);
        @(negedge clk);
        checkOutput("rb_cleared", 32'(bus_a.error), 32'd0);
        waitDoneA("rb_clear_done_seen");
        checkOutput("rb_clear_error", 32'(bus_a.error), 32'd0);
        checkOutput("rb_clear_bits",  32'(a_bits), 32'h0F0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
